// File: rtl/ring_rotator.sv
// ring_rotator
//   Ring of NREGS registers, WIDTH bits each. Commands arrive over a
//   valid/ready handshake and either hold, parallel-load, or rotate the ring
//   forward/reverse by cmd_amt single-position steps (one step per clock).
//   A registered one-cycle done pulse marks completion of every command.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   cmd_valid  command valid
//   cmd_ready  high while IDLE (command can be accepted)
//   cmd_op     00 HOLD, 01 ROT_FWD, 10 ROT_REV, 11 LOAD
//   cmd_amt    step count for rotations
//   load_data  parallel image for LOAD; reg[i] = bits [i*WIDTH +: WIDTH]
//   regs_out   current ring contents, same packing
//   busy       high while ROTATE
//   done       one-cycle completion pulse
module ring_rotator #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 3,
  parameter int unsigned AMT_W = 4,
  parameter logic [WIDTH*NREGS-1:0] RESET_VALS = {4'hC, 4'h8, 4'h5}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [AMT_W-1:0]         cmd_amt,
  input  logic [WIDTH*NREGS-1:0]   load_data,
  output logic [WIDTH*NREGS-1:0]   regs_out,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned W = WIDTH * NREGS;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ROTATE = 1'b1;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_FWD  = 2'b01;
  localparam logic [1:0] OP_REV  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  logic             state;
  logic [W-1:0]     ring;
  logic [AMT_W-1:0] cnt;
  logic             dir_rev;

  // One single-position step of the whole ring. Forward moves reg[i] into
  // reg[i+1] (a left shift of the packed image by one register, wrapping the
  // top register into reg[0]); reverse is the mirror image.
  function automatic logic [W-1:0] step(input logic [W-1:0] img, input logic rev);
    logic [W-1:0] r;
    if (rev)
      r = {img[WIDTH-1:0], img[W-1:WIDTH]};
    else
      r = {img[W-WIDTH-1:0], img[W-1 -: WIDTH]};
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ring    <= RESET_VALS;
      state   <= ST_IDLE;
      cnt     <= '0;
      dir_rev <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_HOLD: done <= 1'b1;
              OP_LOAD: begin
                ring <= load_data;
                done <= 1'b1;
              end
              OP_FWD, OP_REV: begin
                if (cmd_amt == '0) begin
                  done <= 1'b1;
                end else begin
                  // The first step happens on the accept edge itself.
                  ring <= step(ring, cmd_op == OP_REV);
                  if (cmd_amt == AMT_ONE) begin
                    done <= 1'b1;
                  end else begin
                    cnt     <= cmd_amt - AMT_ONE;
                    dir_rev <= (cmd_op == OP_REV);
                    state   <= ST_ROTATE;
                  end
                end
              end
              default: done <= 1'b0;
            endcase
          end
        end
        ST_ROTATE: begin
          ring <= step(ring, dir_rev);
          cnt  <= cnt - AMT_ONE;
          if (cnt == AMT_ONE) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_ROTATE);
  assign regs_out  = ring;

endmodule

// File: tb/tb_ring_rotator.sv
module tb_ring_rotator;

  localparam int N  = 3;
  localparam int WD = 4;
  localparam int W  = N * WD;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] FWD  = 2'b01;
  localparam logic [1:0] REV  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  localparam logic [W-1:0] RST_IMG = 12'hC85;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [3:0]   cmd_amt;
  logic [W-1:0] load_data;
  logic [W-1:0] regs_out;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  ring_rotator #(
    .WIDTH(WD), .NREGS(N), .AMT_W(4), .RESET_VALS(RST_IMG)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .load_data(load_data),
    .regs_out(regs_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: after k forward steps every register holds the value that
  // was k positions below it (mod N); reverse looks k positions above.
  function automatic logic [W-1:0] model_rot(input logic [W-1:0] img, input int k, input bit rev);
    logic [WD-1:0] old [N];
    logic [W-1:0]  res;
    int src;
    for (int i = 0; i < N; i++) old[i] = img[i*WD +: WD];
    res = '0;
    for (int i = 0; i < N; i++) begin
      src = rev ? (i + k) % N : ((i - (k % N)) + N) % N;
      res[i*WD +: WD] = old[src];
    end
    return res;
  endfunction

  // Issue one command and follow it to its done pulse. Garbage is driven
  // on the command inputs while busy; it must be ignored.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] amt,
                         input logic [W-1:0] data, input string tag,
                         output logic [W-1:0] img, output int lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; load_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      check({tag, " ready_low"}, {31'd0, cmd_ready}, 32'd0);
      cmd_valid = 1'($urandom); cmd_op = 2'($urandom); cmd_amt = 4'($urandom);
      load_data = W'($urandom);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat++;
    end
    check({tag, " ready_at_done"}, {31'd0, cmd_ready}, 32'd1);
    img = regs_out;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("reset regs", 32'(regs_out), 32'(RST_IMG));
    check("reset ready", {31'd0, cmd_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [3:0]   amt;
    logic [W-1:0] data;
    logic [W-1:0] exp_img;
    int           exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [W-1:0] img;
    logic [W-1:0] model;
    logic [1:0]   op;
    logic [3:0]   amt;
    logic [W-1:0] data;
    int lat, elat, seen_done;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_amt = '0; load_data = '0;
    #12;
    do_reset();

    // Each vector is applied from the reset image.
    vecs[0] = '{HOLD, 4'd5,  12'hABC, 12'hC85, 1};
    vecs[1] = '{FWD,  4'd0,  12'h000, 12'hC85, 1};
    vecs[2] = '{FWD,  4'd1,  12'h000, 12'h85C, 1};
    vecs[3] = '{FWD,  4'd3,  12'h000, 12'hC85, 3};
    vecs[4] = '{REV,  4'd1,  12'h000, 12'h5C8, 1};
    vecs[5] = '{REV,  4'd2,  12'h000, 12'h85C, 2};
    vecs[6] = '{LOAD, 4'd7,  12'h321, 12'h321, 1};
    vecs[7] = '{FWD,  4'd2,  12'h000, 12'h5C8, 2};
    vecs[8] = '{REV,  4'd15, 12'h000, 12'hC85, 15};
    vecs[9] = '{FWD,  4'd4,  12'h000, 12'h85C, 4};

    for (int v = 0; v < 10; v++) begin
      run_cmd(vecs[v].op, vecs[v].amt, vecs[v].data, $sformatf("vec%0d", v), img, lat);
      check($sformatf("vec%0d regs", v), 32'(img), 32'(vecs[v].exp_img));
      check($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      @(posedge clk); #1;
      check($sformatf("vec%0d done_once", v), {31'd0, done}, 32'd0);
      do_reset();
    end

    // LOAD then ROT_REV 2 back-to-back.
    run_cmd(LOAD, 4'd0, 12'h321, "b2b load", img, lat);
    check("b2b load regs", 32'(img), 32'h321);
    run_cmd(REV, 4'd2, 12'h000, "b2b rev", img, lat);
    check("b2b rev regs", 32'(img), 32'h213);
    check("b2b rev latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    check("b2b done_once", {31'd0, done}, 32'd0);

    // Reset in the middle of a long rotation: no done pulse afterwards.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = FWD; cmd_amt = 4'd15;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid regs before reset", 32'(regs_out), 32'(model_rot(12'h213, 4, 1'b0)));
    do_reset();
    seen_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("mid reset no done", 32'(seen_done), 32'd0);
    check("mid reset regs held", 32'(regs_out), 32'(RST_IMG));
    check("mid reset idle", {31'd0, busy}, 32'd0);

    // Randomized commands against the reference model.
    model = RST_IMG;
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom); amt = 4'($urandom_range(0, 15)); data = W'($urandom);
      case (op)
        LOAD:    model = data;
        FWD:     model = model_rot(model, int'(amt), 1'b0);
        REV:     model = model_rot(model, int'(amt), 1'b1);
        default: model = model;
      endcase
      elat = ((op == FWD || op == REV) && amt > 1) ? int'(amt) : 1;
      run_cmd(op, amt, data, $sformatf("rnd%0d", t), img, lat);
      check($sformatf("rnd%0d regs", t), 32'(img), 32'(model));
      check($sformatf("rnd%0d latency", t), 32'(lat), 32'(elat));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
